mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Data-memory stage: LB/LBU/LW/SB/SW over a req/ack data bus, 1-cycle passthrough for non-memory ops.
// Memory ops take >=3 edges; stallreq freezes upstream until DONE, misaligned words abort with a pulse.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;

  state_t      state, state_nxt;
  logic [31:0] rdata_q;
  logic        op_valid, is_word, is_store, misaligned, start;
  logic [7:0]  rd_byte;
  logic [31:0] result;

  always_comb begin
    op_valid   = (mem_op >= OP_LB) && (mem_op <= OP_SW);
    is_word    = (mem_op == OP_LW) || (mem_op == OP_SW);
    is_store   = (mem_op == OP_SB) || (mem_op == OP_SW);
    misaligned = is_word && (mem_addr[1:0] != 2'b00);
    start      = op_valid && !misaligned;
  end

  // Byte lane selection is little-endian: lane k holds bits [8k+7:8k].
  always_comb begin
    rd_byte = rdata_q[7:0];
    case (mem_addr[1:0])
      2'd0:    rd_byte = rdata_q[7:0];
      2'd1:    rd_byte = rdata_q[15:8];
      2'd2:    rd_byte = rdata_q[23:16];
      default: rd_byte = rdata_q[31:24];
    endcase
  end

  always_comb begin
    result = mem_wdata;
    case (mem_op)
      OP_LB:   result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  result = {24'd0, rd_byte};
      OP_LW:   result = rdata_q;
      default: result = mem_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (bus_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallreq = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stallreq = start;
        BUSY:    stallreq = 1'b1;
        default: stallreq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      wb_wd     <= 5'd0;
      wb_wreg   <= 1'b0;
      wb_wdata  <= 32'd0;
      misalign  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            wb_wd    <= 5'd0;
            wb_wreg  <= 1'b0;
            wb_wdata <= 32'd0;
          end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= is_word ? 4'b1111 : (4'b0001 << mem_addr[1:0]);
            bus_wdata <= (mem_op == OP_SW) ? mem_sdata
                       : (mem_op == OP_SB) ? {4{mem_sdata[7:0]}} : 32'd0;
          end else if (op_valid) begin
            misalign <= 1'b1;
          end
        end
        BUSY: begin
          wb_wd    <= 5'd0;
          wb_wreg  <= 1'b0;
          wb_wdata <= 32'd0;
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            rdata_q <= bus_rdata;
          end
        end
        DONE: begin
          wb_wd    <= mem_wd;
          wb_wreg  <= mem_wreg;
          wb_wdata <= result;
        end
        default: begin
          wb_wd    <= 5'd0;
          wb_wreg  <= 1'b0;
          wb_wdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
